computer_nbit: RTL and testbench

Parametrised successor to the team's 4-bit accumulator computer. It provides a DATA_W-bit A/B datapath, a 2^ADDR_W-entry instruction and data memory, and a bounded STACK_DEPTH hardware stack with overflow and underflow detection. Program loading and execution are separated by a load/start handshake. Flags are defined per result, and d_out carries a valid strobe. It sits as a standalone core fed by a host-side loader.

---
 rtl/computer_pkg.sv | 30 +++
 rtl/computer_stack.sv | 49 ++++
 rtl/computer_nbit.sv | 178 +++++++++++++++++
 tb/tb_computer_nbit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/computer_pkg.sv
// Shared opcode and FSM state encodings for the computer_nbit core.
package computer_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_XCHG = 4'h2,
        OP_RCL  = 4'h3,
        OP_OUT  = 4'h4,
        OP_INC  = 4'h5,
        OP_LDB  = 4'h6,
        OP_MOVB = 4'h7,
        OP_JMP  = 4'h8,
        OP_PUSH = 4'h9,
        OP_POP  = 4'hA,
        OP_NOT  = 4'hB,
        OP_CALL = 4'hC,
        OP_RET  = 4'hD,
        OP_TEST = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

endpackage

// File: rtl/computer_stack.sv
// Bounded LIFO with SP counter; flags a push when full or a pop when empty.
module computer_stack #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              ovf,
    output logic              udf
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0] FULL_SP = SP_W'(STACK_DEPTH);

    logic [DATA_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_dec;
    logic              full;
    logic              empty;

    assign full   = (sp == FULL_SP);
    assign empty  = (sp == '0);
    assign ovf    = push && full;
    assign udf    = pop && empty;
    assign sp_dec = sp - SP_W'(1);
    assign dout   = mem[sp_dec[SP_W-2:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp <= '0;
        else if (clr)
            sp <= '0;
        else if (push && !full)
            sp <= sp + SP_W'(1);
        else if (pop && !empty)
            sp <= sp_dec;
    end

    // Entries are not reset; SP alone defines what is live.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[sp[SP_W-2:0]] <= din;
    end

endmodule

// File: rtl/computer_nbit.sv
// Accumulator computer core: FETCH/EXEC FSM, A/B datapath, instruction and data memory.
module computer_nbit
    import computer_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [4+DATA_W-1:0] load_ins,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                start,
    output logic [DATA_W-1:0]   d_out,
    output logic                out_valid,
    output logic                ZF,
    output logic                CF,
    output logic                busy,
    output logic                halted,
    output logic                stack_err
);
    localparam int IW    = 4 + DATA_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [IW-1:0]     imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    state_e            state;
    logic [ADDR_W-1:0] ip;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] a, b;

    opcode_e           op;
    logic [DATA_W-1:0] opnd;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] ip_inc;
    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] a_inc, a_not;
    logic              idle_like, exec;
    logic              stk_push, stk_pop, stk_ovf, stk_udf, fault;
    logic [DATA_W-1:0] stk_din, stk_dout;

    assign op        = opcode_e'(ir[3:0]);
    assign opnd      = ir[IW-1:4];
    assign addr      = opnd[ADDR_W-1:0];
    assign ip_inc    = ip + ADDR_W'(1);
    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};
    assign a_inc     = a + DATA_W'(1);
    assign a_not     = ~a;
    assign idle_like = (state == S_IDLE) || (state == S_HALT);
    assign exec      = (state == S_EXEC);

    assign stk_push = exec && (op == OP_PUSH || op == OP_CALL);
    assign stk_pop  = exec && (op == OP_POP  || op == OP_RET);
    assign stk_din  = (op == OP_CALL) ? DATA_W'(ip_inc) : b;
    assign fault    = stk_ovf || stk_udf;

    computer_stack #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start && idle_like),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .ovf   (stk_ovf),
        .udf   (stk_udf)
    );

    // Memories survive reset; the loader owns them outside of execution.
    always_ff @(posedge clk) begin
        if (load_en && idle_like) begin
            imem[load_addr] <= load_ins;
            dmem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ip        <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            d_out     <= '0;
            out_valid <= 1'b0;
            ZF        <= 1'b0;
            CF        <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state     <= S_FETCH;
                        ip        <= '0;
                        a         <= '0;
                        b         <= '0;
                        ZF        <= 1'b0;
                        CF        <= 1'b0;
                        busy      <= 1'b1;
                        halted    <= 1'b0;
                        stack_err <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= imem[ip];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    ip    <= ip_inc;
                    if (fault) begin
                        // Faulting op leaves IP, B and the stack as they were.
                        ip        <= ip;
                        stack_err <= 1'b1;
                        halted    <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_HALT;
                    end else begin
                        case (op)
                            OP_ADD:  begin
                                {CF, a} <= sum;
                                ZF      <= (sum[DATA_W-1:0] == '0);
                            end
                            OP_SUB:  begin
                                {CF, a} <= diff;
                                ZF      <= (diff[DATA_W-1:0] == '0);
                            end
                            OP_XCHG: begin
                                a <= b;
                                b <= a;
                            end
                            OP_RCL:  {CF, a} <= {a, CF};
                            OP_OUT:  begin
                                d_out     <= a;
                                out_valid <= 1'b1;
                            end
                            OP_INC:  begin
                                a  <= a_inc;
                                ZF <= (a_inc == '0);
                            end
                            OP_LDB:  b <= dmem[addr];
                            OP_MOVB: b <= opnd;
                            OP_JMP:  ip <= addr;
                            OP_PUSH: ;
                            OP_POP:  b <= stk_dout;
                            OP_NOT:  begin
                                a  <= a_not;
                                ZF <= (a_not == '0);
                            end
                            OP_CALL: ip <= addr;
                            OP_RET:  ip <= stk_dout[ADDR_W-1:0];
                            OP_TEST: ZF <= ((a & b) == '0);
                            OP_HLT:  begin
                                ip     <= ip;
                                halted <= 1'b1;
                                busy   <= 1'b0;
                                state  <= S_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_computer_nbit.sv
// Scoreboard bench for computer_nbit: a program-level model predicts OUT values, flags and halt time.
module tb_computer_nbit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [11:0] load_ins = '0;
    logic [7:0]  load_data = '0;
    logic        start = 1'b0;
    logic [7:0]  d_out;
    logic        out_valid, ZF, CF, busy, halted, stack_err;

    computer_nbit #(.DATA_W(8), .ADDR_W(4), .STACK_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_ins  (load_ins),
        .load_data (load_data),
        .start     (start),
        .d_out     (d_out),
        .out_valid (out_valid),
        .ZF        (ZF),
        .CF        (CF),
        .busy      (busy),
        .halted    (halted),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int mq[$];
    int last_out = 0;
    logic [11:0] timem [16];
    logic [7:0]  tdmem [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every OUT strobe must match the next predicted value.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0d expected none", d_out);
            end else begin
                chk("out_value", d_out, exp_q.pop_front());
            end
        end
    end

    // Instruction-level reference: runs the program in timem/tdmem with integer arithmetic.
    task automatic model(output int n, output bit z, output bit c, output bit err, output bit ok);
        int a, b, ip, nip, w, op, opnd, ad, t;
        int stk[$];
        a = 0; b = 0; ip = 0; n = 0; z = 0; c = 0; err = 0; ok = 0;
        mq = {};
        while (n < 64) begin
            w = timem[ip]; op = w % 16; opnd = w / 16; ad = opnd % 16;
            n++;
            nip = (ip + 1) % 16;
            case (op)
                0:  begin a = a + b; c = (a > 255); a = a % 256; z = (a == 0); end
                1:  begin c = (a < b); a = (a - b + 256) % 256; z = (a == 0); end
                2:  begin t = a; a = b; b = t; end
                3:  begin t = a / 128; a = (a * 2 + c) % 256; c = t[0]; end
                4:  mq.push_back(a);
                5:  begin a = (a + 1) % 256; z = (a == 0); end
                6:  b = tdmem[ad];
                7:  b = opnd;
                8:  nip = ad;
                9:  begin if (stk.size() == 4) begin err = 1; ok = 1; return; end stk.push_back(b); end
                10: begin if (stk.size() == 0) begin err = 1; ok = 1; return; end b = stk.pop_back(); end
                11: begin a = 255 - a; z = (a == 0); end
                12: begin if (stk.size() == 4) begin err = 1; ok = 1; return; end stk.push_back(nip); nip = ad; end
                13: begin if (stk.size() == 0) begin err = 1; ok = 1; return; end nip = stk.pop_back() % 16; end
                14: z = ((a & b) == 0);
                default: begin ok = 1; return; end
            endcase
            ip = nip;
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            load_en = 1'b1; load_addr = 4'(i); load_ins = timem[i]; load_data = tdmem[i];
        end
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            timem[i] = 12'h00F;
            tdmem[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // ld0: write w0 at address 0 in the start cycle; bz: hammer load/start while busy.
    task automatic go(input string nm, input bit ld0, input logic [11:0] w0, input bit bz);
        int n, cyc;
        bit z, c, err, ok;
        if (ld0) timem[0] = w0;
        model(n, z, c, err, ok);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_model: got no halt expected halt", nm);
            return;
        end
        foreach (mq[i]) exp_q.push_back(mq[i]);
        if (mq.size() > 0) last_out = mq[mq.size()-1];
        @(posedge clk); #1;
        start = 1'b1;
        if (ld0) begin
            load_en = 1'b1; load_addr = 4'd0; load_ins = w0; load_data = tdmem[0];
        end
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        if (bz) begin
            start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_ins = 12'h00F; load_data = 8'hAA;
        end
        chk({nm, "_busy"}, busy, 1);
        cyc = 0;
        while (halted !== 1'b1 && cyc < 400) begin
            @(posedge clk); cyc++; #1;
            if (bz && cyc == 4) begin start = 1'b0; load_en = 1'b0; end
        end
        start = 1'b0; load_en = 1'b0;
        chk({nm, "_halt_edge"}, cyc, 2 * n);
        chk({nm, "_zf"}, ZF, z);
        chk({nm, "_cf"}, CF, c);
        chk({nm, "_stack_err"}, stack_err, err);
        chk({nm, "_busy_low"}, busy, 0);
        chk({nm, "_dout"}, d_out, last_out);
        chk({nm, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n; bit z, c, err, ok;
        #2;
        chk("rst_dout", d_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_zf", ZF, 0);
        chk("rst_cf", CF, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stack_err", stack_err, 0);
        #20 rst_n = 1'b1;

        // MOV B,5; ADD; MOV B,3; ADD; OUT; HLT
        clear_prog();
        timem[0] = 12'h057; timem[1] = 12'h000; timem[2] = 12'h037;
        timem[3] = 12'h000; timem[4] = 12'h004; timem[5] = 12'h00F;
        load_all();
        go("t1", 0, '0, 0);
        chk("t1_const_dout", d_out, 8);

        // NOT; MOV B,1; ADD; OUT; RCL; OUT; HLT
        clear_prog();
        timem[0] = 12'h00B; timem[1] = 12'h017; timem[2] = 12'h000; timem[3] = 12'h004;
        timem[4] = 12'h003; timem[5] = 12'h004; timem[6] = 12'h00F;
        load_all();
        go("t2", 0, '0, 0);
        chk("t2_const_dout", d_out, 1);
        chk("t2_const_cf", CF, 0);
        chk("t2_const_zf", ZF, 1);

        // CALL 8; HLT; ... 8: INC; OUT; RET
        clear_prog();
        timem[0] = 12'h08C; timem[1] = 12'h00F;
        timem[8] = 12'h005; timem[9] = 12'h004; timem[10] = 12'h00D;
        load_all();
        go("call", 0, '0, 0);
        chk("call_const_dout", d_out, 1);

        clear_prog();
        for (int i = 0; i < 5; i++) timem[i] = 12'h009;
        load_all();
        go("ovf", 0, '0, 0);
        chk("ovf_const_err", stack_err, 1);

        clear_prog();
        timem[0] = 12'h00A;
        load_all();
        go("udf", 0, '0, 0);
        chk("udf_const_err", stack_err, 1);

        // Reset mid-run, during the EXEC of the first ADD
        clear_prog();
        timem[0] = 12'h057; timem[1] = 12'h000; timem[2] = 12'h037;
        timem[3] = 12'h000; timem[4] = 12'h004; timem[5] = 12'h00F;
        load_all();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", d_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        #3 rst_n = 1'b1;
        last_out = 0;
        go("rerun", 0, '0, 0);

        go("busy_ign", 0, '0, 1);
        go("after_busy", 0, '0, 0);
        go("ld_start", 1, 12'h004, 0);

        for (int r = 0; r < 10; r++) begin
            ok = 0;
            for (int t = 0; t < 50 && !ok; t++) begin
                for (int i = 0; i < 16; i++) begin
                    timem[i] = 12'($urandom_range(0, 4095));
                    tdmem[i] = 8'($urandom_range(0, 255));
                end
                model(n, z, c, err, ok);
            end
            if (!ok) clear_prog();
            load_all();
            go("rand", 0, '0, 0);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
